mesa_cmd_tx: RTL and testbench
==============================

// Module: mesa_cmd_tx
// PURPOSE
//  Command-side driver for the table-status controller (4 tables x 3 states L/O/R).
//  Queues host commands {table, state} through a valid/ready port in a small FIFO.
//  Replays each command as one-hot table/state strobes (outmes1-4, outest0-2), feeding the controller's inmes1-4/inest0-2.
//  Each strobe pair is held HOLD_CYCLES, then all lines stay low for GAP_CYCLES, so the receiver never sees overlapping or stale pairs.
// PARAMETERS
//  HOLD_CYCLES  3  cycles a table+state strobe pair stays asserted (1..255)
//  GAP_CYCLES   2  cycles all strobes stay low after a hold (1..255)
//  DEPTH        4  command FIFO entries (power of 2, >=2)
// PORTS
//  clk         in   1   single system clock, all logic on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  cmd_valid   in   1   host offers a command
//  cmd_ready   out  1   FIFO can accept; equals !full
//  cmd_mesa    in   2   table index 0..3 -> outmes1..outmes4
//  cmd_est     in   2   state 0=L(outest0) 1=O(outest1) 2=R(outest2); 3 illegal
//  outmes1..4  out  1ea one-hot table strobe to the controller
//  outest0..2  out  1ea one-hot state strobe to the controller
//  busy        out  1   high in DRIVE or GAP, or when the FIFO is non-empty
//  err_pulse   out  1   one-cycle pulse when an illegal command is accepted
//  fifo_count  out  $clog2(DEPTH)+1  entries currently queued
// BEHAVIOUR
//  Reset (async assert, sync release): FIFO empty, count 0, FSM=IDLE; all strobes, busy and err_pulse at 0; cmd_ready=1.
//  Reset mid-hold drops strobes immediately and discards all queued commands.
//  Accept rule: a command is taken on the edge where cmd_valid && cmd_ready.
//  Legal accepted commands are pushed to the FIFO.
//  cmd_est==3: command is accepted but not pushed; err_pulse=1 on the next cycle only. FIFO and FSM are unaffected.
//  cmd_ready = !full, registered-state based. A pop on the same edge does not allow a push when full.
//  Push and pop on the same edge (not full, not empty): count unchanged. Pointers wrap modulo DEPTH.
//  FSM IDLE: if FIFO non-empty, pop the head on this edge and go to DRIVE with counter=HOLD_CYCLES-1. Otherwise stay in IDLE.
//  FSM DRIVE: exactly one outmesN and one outestK are high, registered from the popped entry.
//    Decrement the counter. At 0, go to GAP with counter=GAP_CYCLES-1.
//  FSM GAP: all strobes low. Decrement the counter. At 0, go to IDLE.
//  Strobes are never asserted outside DRIVE. Strobes change only on DRIVE entry and exit, never one line at a time.
//  Latency: command pushed at edge N into an empty FIFO in IDLE -> popped at N+1; strobes high N+1..N+HOLD.
//  Back-to-back spacing: strobe rising edges are HOLD+GAP+1 cycles apart.
//  Commands keep arrival order. No command is dropped while cmd_ready=1 except illegal ones.
//  Identical consecutive commands are each replayed in full; no merging.
// TESTING (HOLD=3, GAP=2, DEPTH=4)
//  Reset, then push {mesa=1,est=2} -> outmes2&outest2 high exactly 3 cycles starting 1 cycle after accept.
//    Then 2 low cycles; busy falls in IDLE.
//  Push {0,0},{3,1} back-to-back -> pair1 high 3, low 2, idle 1, then outmes4&outest1 high 3; rising edges 6 cycles apart.
//  Push 5 commands with the FSM stalled in the first DRIVE -> cmd_ready=0 at count 4.
//    The 5th is held off until the first pop; order preserved.
//  Push {2,3} -> err_pulse high 1 cycle, fifo_count stays 0, no strobe activity.
//  Assert rst_n=0 in cycle 2 of a hold with 2 entries queued -> strobes 0 same cycle.
//    fifo_count=0, cmd_ready=1 after release, nothing replayed.
//  Every cycle, check: at most one outmes and one outest high, and both high or both low.

Source files
------------

// File: rtl/mesa_cmd_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mesa_cmd_tx                                                     |
// | Desc     : Queues {table,state} host commands and replays each one as a    |
// |            one-hot strobe pair held HOLD_CYCLES, then GAP_CYCLES low.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mesa_cmd_tx #(
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 2,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_mesa,
  input  logic [1:0]               cmd_est,
  output logic                     outmes1,
  output logic                     outmes2,
  output logic                     outmes3,
  output logic                     outmes4,
  output logic                     outest0,
  output logic                     outest1,
  output logic                     outest2,
  output logic                     busy,
  output logic                     err_pulse,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  HOLD_LD  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]  GAP_LD   = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      mes_q, mes_d;
  logic [2:0]      est_q, est_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            err_q;
  logic [3:0]      mem_q [DEPTH];

  logic            w_full;
  logic            w_accept;
  logic            w_illegal;
  logic            w_push;
  logic            w_pop;
  logic [3:0]      w_head;

  assign w_full    = (count_q == FULL_CNT);
  assign w_accept  = cmd_valid && !w_full;
  assign w_illegal = w_accept && (cmd_est == 2'd3);
  assign w_push    = w_accept && (cmd_est != 2'd3);
  assign w_pop     = (state_q == S_IDLE) && (count_q != '0);
  assign w_head    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {cmd_mesa, cmd_est};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      err_q   <= w_illegal;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mes_d   = mes_q;
    est_d   = est_q;
    case (state_q)
      S_IDLE: begin
        if (w_pop) begin
          state_d = S_DRIVE;
          cnt_d   = HOLD_LD;
          mes_d   = 4'b0001 << w_head[3:2];
          est_d   = 3'b001 << w_head[1:0];
        end
      end
      S_DRIVE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
          mes_d   = 4'b0000;
          est_d   = 3'b000;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        mes_d   = 4'b0000;
        est_d   = 3'b000;
      end
    endcase
  end

  // Strobes are whole-pair registers so they switch together on DRIVE entry/exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      mes_q   <= 4'b0000;
      est_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mes_q   <= mes_d;
      est_q   <= est_d;
    end
  end

  assign cmd_ready  = !w_full;
  assign outmes1    = mes_q[0];
  assign outmes2    = mes_q[1];
  assign outmes3    = mes_q[2];
  assign outmes4    = mes_q[3];
  assign outest0    = est_q[0];
  assign outest1    = est_q[1];
  assign outest2    = est_q[2];
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign err_pulse  = err_q;
  assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mesa_cmd_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mesa_cmd_tx                                                  |
// | Desc     : Scoreboard bench for mesa_cmd_tx with directed command vectors. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mesa_cmd_tx;

  localparam int HOLD  = 3;
  localparam int GAP   = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mesa;
  logic [1:0] cmd_est;
  logic       outmes1, outmes2, outmes3, outmes4;
  logic       outest0, outest1, outest2;
  logic       busy;
  logic       err_pulse;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cyc;
  int idle_cyc;
  logic [3:0] sb[$];
  int rise_q[$];

  mesa_cmd_tx #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mesa  (cmd_mesa),
    .cmd_est   (cmd_est),
    .outmes1   (outmes1),
    .outmes2   (outmes2),
    .outmes3   (outmes3),
    .outmes4   (outmes4),
    .outest0   (outest0),
    .outest1   (outest1),
    .outest2   (outest2),
    .busy      (busy),
    .err_pulse (err_pulse),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle pair invariants, and a scoreboard pop on every strobe rise.
  logic [3:0] prev_mes = 4'b0;
  logic [2:0] prev_est = 3'b0;
  int         run_len  = 0;
  always @(negedge clk) begin
    logic [3:0] mes;
    logic [2:0] est;
    logic [3:0] e;
    if (!rst_n) begin
      prev_mes = 4'b0;
      prev_est = 3'b0;
      run_len  = 0;
    end else begin
      mes = {outmes4, outmes3, outmes2, outmes1};
      est = {outest2, outest1, outest0};
      chk("mes_onehot0", int'($countones(mes) <= 1), 1);
      chk("est_onehot0", int'($countones(est) <= 1), 1);
      chk("pair_together", int'((mes != 0) == (est != 0)), 1);
      if (mes != 0 && prev_mes == 0) begin
        rise_q.push_back(cyc);
        run_len = 1;
        if (sb.size() == 0) begin
          chk("unexpected_strobe", int'(mes), 0);
        end else begin
          e = sb.pop_front();
          chk("strobe_mes", int'(mes), int'(4'b0001 << e[3:2]));
          chk("strobe_est", int'(est), int'(3'b001 << e[1:0]));
        end
      end else if (mes != 0) begin
        run_len++;
        chk("strobe_stable", int'({mes, est} == {prev_mes, prev_est}), 1);
      end else if (prev_mes != 0) begin
        chk("hold_len", run_len, HOLD);
      end
      prev_mes = mes;
      prev_est = est;
    end
  end

  task automatic send(input logic [1:0] m, input logic [1:0] e);
    int   n;
    logic acc;
    n = 0;
    cmd_valid = 1'b1;
    cmd_mesa  = m;
    cmd_est   = e;
    while (1) begin
      acc = cmd_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 40) begin
        chk("accept_timeout", 0, 1);
        cmd_valid = 1'b0;
        return;
      end
    end
    acc_cyc = cyc;
    if (e != 2'd3) sb.push_back({m, e});
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < bound);
    if (busy) chk("idle_timeout", 1, 0);
    idle_cyc = cyc;
  endtask

  task automatic wait_strobe();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ({outmes4, outmes3, outmes2, outmes1} == 4'b0 && n < 20);
    if ({outmes4, outmes3, outmes2, outmes1} == 4'b0) chk("strobe_timeout", 0, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mesa  = 2'd0;
    cmd_est   = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_pulse), 0);
    chk("rst_strobes", int'({outmes4, outmes3, outmes2, outmes1, outest2, outest1, outest0}), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single command: latency 1, hold 3, gap 2, then idle.
    rise_q.delete();
    send(2'd1, 2'd2);
    wait_idle(50);
    chk("t1_rises", rise_q.size(), 1);
    if (rise_q.size() >= 1) chk("t1_latency", rise_q[0] - acc_cyc, 1);
    chk("t1_busy_fall", idle_cyc - acc_cyc, 1 + HOLD + GAP);
    chk("t1_count", int'(fifo_count), 0);

    // Back-to-back pair: rising edges HOLD+GAP+1 apart.
    rise_q.delete();
    send(2'd0, 2'd0);
    send(2'd3, 2'd1);
    wait_idle(50);
    chk("t2_rises", rise_q.size(), 2);
    if (rise_q.size() >= 2) chk("t2_spacing", rise_q[1] - rise_q[0], HOLD + GAP + 1);

    // Fill FIFO while the first command drives; fifth is held off until a pop.
    send(2'd0, 2'd1);
    wait_strobe();
    send(2'd1, 2'd1);
    send(2'd2, 2'd2);
    send(2'd3, 2'd0);
    send(2'd0, 2'd2);
    chk("t3_full_count", int'(fifo_count), 4);
    chk("t3_full_ready", int'(cmd_ready), 0);
    send(2'd1, 2'd0);
    wait_idle(200);
    chk("t3_drain_count", int'(fifo_count), 0);

    // Illegal state: err pulse only, nothing queued.
    send(2'd2, 2'd3);
    chk("t4_err_high", int'(err_pulse), 1);
    chk("t4_count", int'(fifo_count), 0);
    chk("t4_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    chk("t4_err_low", int'(err_pulse), 0);
    repeat (4) @(posedge clk);
    #1;

    // Reset during second hold cycle with two entries queued.
    send(2'd2, 2'd0);
    send(2'd1, 2'd1);
    send(2'd0, 2'd2);
    chk("t5_pre_count", int'(fifo_count), 2);
    chk("t5_pre_mes3", int'(outmes3), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_strobes_drop", int'({outmes4, outmes3, outmes2, outmes1, outest2, outest1, outest0}), 0);
    chk("t5_rst_count", int'(fifo_count), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("t5_post_count", int'(fifo_count), 0);
    chk("t5_post_ready", int'(cmd_ready), 1);
    chk("t5_post_busy", int'(busy), 0);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
